// File: rtl/ysyx_22050019_wbu.sv
// ysyx_22050019_wbu
// Write-back unit with an integrated 32 x XLEN general-purpose register file.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid / in_ready   write-back bundle handshake from the execute stage
//   in_we, in_waddr,      bundle contents: write enable, destination index
//   in_wdata              and data
//   wb_stall              holds retirement while high
//   raddr1/2, rdata1/2    two combinational read ports, with bypass from
//                         buffered but not-yet-retired writes
//   commit_valid          head entry retires at the coming clock edge
//   commit_we/waddr/wdata head entry contents (zero when the buffer is empty)
//   retire_cnt            number of entries retired since reset
//
// Accepted bundles sit in a 2-entry in-order buffer and retire one per cycle.

module ysyx_22050019_wbu #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_we,
  input  logic [4:0]      in_waddr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            wb_stall,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            commit_valid,
  output logic            commit_we,
  output logic [4:0]      commit_waddr,
  output logic [XLEN-1:0] commit_wdata,
  output logic [63:0]     retire_cnt
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic            buf_we    [DEPTH];
  logic [4:0]      buf_waddr [DEPTH];
  logic [XLEN-1:0] buf_wdata [DEPTH];

  logic            head;
  logic            tail;
  logic            young;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] gpr [32];

  logic [4:0]      raddr_v [2];
  logic [XLEN-1:0] rdata_v [2];

  // in_ready depends only on the stored count, so a pop in the same cycle
  // never opens a slot for a bundle arriving while the buffer is full.
  assign in_ready     = (count != FULL);
  assign push         = in_valid && in_ready;
  assign commit_valid = (count != 2'd0) && !wb_stall;
  assign pop          = commit_valid;

  // Youngest buffered entry sits one slot behind the tail pointer.
  assign young = tail - 1'b1;

  // Buffer pointers, occupancy and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_we[i]    <= 1'b0;
        buf_waddr[i] <= 5'd0;
        buf_wdata[i] <= '0;
      end
    end else begin
      if (push) begin
        buf_we[tail]    <= in_we;
        buf_waddr[tail] <= in_waddr;
        buf_wdata[tail] <= in_wdata;
        tail            <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Register file update at retirement; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        gpr[i] <= '0;
      end
    end else if (pop && buf_we[head] && (buf_waddr[head] != 5'd0)) begin
      gpr[buf_waddr[head]] <= buf_wdata[head];
    end
  end

  // Retirement counter counts every retired entry, writing or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= 64'd0;
    end else if (pop) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end

  // Head entry is exposed whenever the buffer is non-empty, even if stalled.
  always_comb begin
    commit_we    = 1'b0;
    commit_waddr = 5'd0;
    commit_wdata = '0;
    if (count != 2'd0) begin
      commit_we    = buf_we[head];
      commit_waddr = buf_waddr[head];
      commit_wdata = buf_wdata[head];
    end
  end

  assign raddr_v[0] = raddr1;
  assign raddr_v[1] = raddr2;
  assign rdata1     = rdata_v[0];
  assign rdata2     = rdata_v[1];

  // Read ports: later assignments override earlier ones, so the order below
  // runs from lowest to highest priority (gpr, head, youngest, x0). With a
  // single buffered entry head and youngest are the same slot.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_v[p] = gpr[raddr_v[p]];
      if ((count != 2'd0) && buf_we[head] && (buf_waddr[head] == raddr_v[p])) begin
        rdata_v[p] = buf_wdata[head];
      end
      if ((count != 2'd0) && buf_we[young] && (buf_waddr[young] == raddr_v[p])) begin
        rdata_v[p] = buf_wdata[young];
      end
      if (raddr_v[p] == 5'd0) begin
        rdata_v[p] = '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_wbu.sv
// tb_ysyx_22050019_wbu
// Scoreboard bench for the write-back unit. The stimulus process drives
// bundles on the falling edge and records accepted ones in a queue that
// models the buffer; a monitor process compares every DUT output each cycle
// against a reference model (queue plus register array).

module tb_ysyx_22050019_wbu;

  localparam int XLEN = 64;

  typedef struct packed {
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
  } wb_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_we = 1'b0;
  logic [4:0]      in_waddr = 5'd0;
  logic [XLEN-1:0] in_wdata = '0;
  logic            wb_stall = 1'b0;
  logic [4:0]      raddr1 = 5'd0;
  logic [4:0]      raddr2 = 5'd0;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            commit_valid;
  logic            commit_we;
  logic [4:0]      commit_waddr;
  logic [XLEN-1:0] commit_wdata;
  logic [63:0]     retire_cnt;

  wb_t             exp_q[$];
  logic [XLEN-1:0] model_gpr [32];
  logic [63:0]     model_retire;
  int              checks = 0;
  int              fails = 0;

  ysyx_22050019_wbu #(.DEPTH(2), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_we        (in_we),
    .in_waddr     (in_waddr),
    .in_wdata     (in_wdata),
    .wb_stall     (wb_stall),
    .raddr1       (raddr1),
    .raddr2       (raddr2),
    .rdata1       (rdata1),
    .rdata2       (rdata2),
    .commit_valid (commit_valid),
    .commit_we    (commit_we),
    .commit_waddr (commit_waddr),
    .commit_wdata (commit_wdata),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Architectural view of a register: newest buffered write wins, else the
  // committed register value; x0 always reads zero.
  function automatic logic [XLEN-1:0] model_read(input logic [4:0] addr);
    if (addr == 5'd0) return '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].we && exp_q[i].waddr == addr) return exp_q[i].wdata;
    end
    return model_gpr[addr];
  endfunction

  // Monitor: samples after the falling-edge stimulus has settled.
  initial begin
    wb_t      e;
    logic     exp_cv;
    forever begin
      @(negedge clk);
      #2;
      exp_cv = rst_n && (exp_q.size() != 0) && !wb_stall;
      checkOutput("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      checkOutput("commit_valid", 64'(commit_valid), 64'(exp_cv));
      checkOutput("retire_cnt", retire_cnt, model_retire);
      checkOutput("rdata1", rdata1, model_read(raddr1));
      checkOutput("rdata2", rdata2, model_read(raddr2));
      if (exp_q.size() == 0) begin
        checkOutput("commit_idle", {commit_wdata[57:0], commit_waddr, commit_we}, 64'd0);
      end else begin
        e = exp_q[0];
        checkOutput("commit_we", 64'(commit_we), 64'(e.we));
        checkOutput("commit_waddr", 64'(commit_waddr), 64'(e.waddr));
        checkOutput("commit_wdata", commit_wdata, e.wdata);
      end
      if (exp_cv) begin
        e = exp_q.pop_front();
        if (e.we && e.waddr != 5'd0) model_gpr[e.waddr] = e.wdata;
        model_retire = model_retire + 64'd1;
      end
    end
  end

  // One cycle of stimulus; acceptance is decided from the model occupancy.
  task automatic applyStimulus(input logic v, input logic we, input logic [4:0] a,
                               input logic [XLEN-1:0] d, input logic stall,
                               input logic [4:0] r1, input logic [4:0] r2);
    logic acc;
    wb_t  e;
    @(negedge clk);
    in_valid = v;
    in_we    = we;
    in_waddr = a;
    in_wdata = d;
    wb_stall = stall;
    raddr1   = r1;
    raddr2   = r2;
    #1;
    acc = v && rst_n && (exp_q.size() < 2);
    @(posedge clk);
    if (acc) begin
      e.we = we;
      e.waddr = a;
      e.wdata = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic idleCycle(input logic [4:0] r1, input logic [4:0] r2);
    applyStimulus(1'b0, 1'b0, 5'd0, '0, 1'b0, r1, r2);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    wb_stall = 1'b0;
    raddr1   = 5'd5;
    raddr2   = 5'd7;
    exp_q.delete();
    for (int i = 0; i < 32; i++) model_gpr[i] = '0;
    model_retire = 64'd0;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_retire_cnt", retire_cnt, 64'd0);
    checkOutput("rst_rdata_x5", rdata1, 64'd0);
    checkOutput("rst_commit_valid", 64'(commit_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [XLEN-1:0] val;
    for (int i = 0; i < 32; i++) model_gpr[i] = '0;
    model_retire = 64'd0;

    resetDut();

    // x0 write is dropped but still counted
    applyStimulus(1'b1, 1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 5'd0);
    idleCycle(5'd0, 5'd0);
    idleCycle(5'd0, 5'd0);
    #1;
    checkOutput("x0_rdata1", rdata1, 64'd0);
    checkOutput("x0_retire_cnt", retire_cnt, 64'd1);

    // Basic write then read from the register file
    val = 64'h1234_5678_9ABC_DEF0;
    applyStimulus(1'b1, 1'b1, 5'd3, val, 1'b0, 5'd3, 5'd0);
    #1;
    checkOutput("basic_commit_valid", 64'(commit_valid), 64'd1);
    idleCycle(5'd3, 5'd0);
    #1;
    checkOutput("basic_gpr_x3", rdata1, val);

    // Bypass priority and full boundary under stall
    applyStimulus(1'b1, 1'b1, 5'd7, 64'h11, 1'b1, 5'd0, 5'd7);
    applyStimulus(1'b1, 1'b1, 5'd7, 64'h22, 1'b1, 5'd0, 5'd7);
    #1;
    checkOutput("bypass_rdata2_x7", rdata2, 64'h22);
    checkOutput("bypass_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 1'b1, 5'd8, 64'h88, 1'b1, 5'd8, 5'd7);
    #1;
    checkOutput("full_no_push", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 1'b1, 5'd8, 64'h88, 1'b0, 5'd8, 5'd7);
    #1;
    checkOutput("full_ready_after_pop", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 1'b1, 5'd8, 64'h88, 1'b0, 5'd8, 5'd7);
    repeat (3) idleCycle(5'd7, 5'd8);
    #1;
    checkOutput("bypass_final_x7", rdata1, 64'h22);
    checkOutput("full_held_x8", rdata2, 64'h88);

    // Non-writing entry
    applyStimulus(1'b1, 1'b0, 5'd9, 64'hDEAD, 1'b0, 5'd9, 5'd9);
    #1;
    checkOutput("nowr_commit_we", 64'(commit_we), 64'd0);
    checkOutput("nowr_no_bypass", rdata1, 64'd0);
    idleCycle(5'd9, 5'd9);

    // Mid-stream reset with two entries buffered
    applyStimulus(1'b1, 1'b1, 5'd5, 64'h55, 1'b1, 5'd5, 5'd5);
    applyStimulus(1'b1, 1'b1, 5'd6, 64'h66, 1'b1, 5'd5, 5'd6);
    resetDut();

    // Back-to-back stream of 100 pushes
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b1, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'b0,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    idleCycle(5'd0, 5'd0);
    idleCycle(5'd0, 5'd0);
    #1;
    checkOutput("stream_retire_cnt", retire_cnt, 64'd100);
    for (int i = 0; i < 32; i++) idleCycle(5'(i), 5'(31 - i));

    // Random mix of valid, stall and write enable over a few registers
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 7)), {$urandom, $urandom},
                    1'($urandom_range(0, 3) == 0),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Drain with a bounded budget
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idleCycle(5'd1, 5'd2);
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_wbu.md
# ysyx_22050019_wbu

Write-back unit with integrated general-purpose register file. It sits after the execute stage and accepts that stage's write-back bundle (write enable, destination index, 64-bit data) through a valid/ready handshake. Accepted bundles are held in a 2-entry in-order buffer and retired one per cycle into a 32×64 GPR array. Two combinational read ports serve decode, bypassing from buffered, not-yet-retired writes.

## Interface
Parameters:
- `DEPTH`, default 2: write-back buffer entries. Fixed at 2 for this design.
- `XLEN`, default 64: register and data width.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  execute stage presents a write-back bundle
- `in_ready`  out  1  unit can accept a bundle this cycle
- `in_we`  in  1  bundle writes a register
- `in_waddr`  in  5  destination register index
- `in_wdata`  in  XLEN  data to write; don't-care when `in_we`=0
- `wb_stall`  in  1  holds retirement; used for difftest and debug halt
- `raddr1`, `raddr2`  in  5  read port addresses
- `rdata1`, `rdata2`  out  XLEN  read port data, combinational
- `commit_valid`  out  1  head entry retires at this clock edge
- `commit_we`  out  1  head entry write enable
- `commit_waddr`  out  5  head entry destination index
- `commit_wdata`  out  XLEN  head entry data
- `retire_cnt`  out  64  number of entries retired since reset

## Operation
- Buffer:
  - Circular FIFO with 1-bit head/tail pointers and a 2-bit count (0..2).
  - Push when `in_valid && in_ready`.
  - Pop when `commit_valid`.
- `in_ready = (count != 2)`.
  - No pass-through when full: a same-cycle pop does not raise `in_ready`.
- `commit_valid = (count != 0) && !wb_stall`.
  - `commit_we`, `commit_waddr` and `commit_wdata` always reflect the head entry.
  - These three outputs are zero when `count == 0`.
- Retire at the edge where `commit_valid` is high:
  - `gpr[waddr] <= wdata` only if `we` is set and `waddr != 0`.
  - `retire_cnt` increments by 1 on every retirement, including entries with `we=0` and writes to x0.
- x0 is hard-wired to zero. It is never written, and reads always return 0.
- Read data for `rdataN`, highest priority first:
  1. `raddrN == 0` returns 0.
  2. Youngest buffered entry (tail-1) with `we && waddr == raddrN` returns that entry's data.
  3. Older buffered entry (head) with a match returns its data.
  4. Otherwise `gpr[raddrN]`.
- Bypass considers only entries already in the buffer. The bundle on `in_*` during the current cycle is not forwarded.
- Simultaneous push and pop:
  - Allowed whenever count is 1. Count stays 1.
  - A push into an empty buffer is not popped in the same cycle; the earliest retirement is at the next edge.
- Retirement order equals acceptance order. No entry is ever dropped or duplicated.

## Timing
- Reset (async assert, `rst_n`=0):
  - count=0, both pointers 0, all 32 GPRs 0, `retire_cnt`=0.
  - `in_ready`=1, `commit_valid`=0, `commit_*`=0.
  - `rdata1`/`rdata2`=0 for any address.
  - Buffered entries are discarded.
- Reset release: synchronous to `clk`. The first push can occur at the first rising edge after deassertion.
- Latency: a bundle accepted at edge N with `wb_stall`=0:
  - Drives `commit_valid` during cycle N→N+1.
  - Is visible in `gpr` after edge N+1.
  - Is visible on the read ports via bypass from just after edge N.
- Throughput: 1 bundle/cycle sustained while `wb_stall`=0.
- With `wb_stall`=1, at most 2 bundles are accepted. Then `in_ready`=0 until the first unstalled edge.
- Read ports are purely combinational from `raddrN`, buffer contents and `gpr`. There is no read latency.

## Test plan
- Reset/x0:
  - Assert `rst_n`=0 mid-stream with 2 entries buffered → count=0, `in_ready`=1, `retire_cnt`=0, and reading x5 returns 0.
  - Push we=1, waddr=0, wdata=0xFFFF → `rdata1` for x0 stays 0 and `retire_cnt`=1.
- Basic write/read:
  - Push x3=0x1234_5678_9ABC_DEF0 → `commit_valid` is high the next cycle.
  - After the retire edge, `raddr1`=3 returns the same value from `gpr`.
- Bypass priority:
  - Setup: `wb_stall`=1; push x7=0x11, then x7=0x22.
  - `rdata2` (`raddr2`=7) returns 0x22 and `in_ready`=0.
  - Release the stall → retire order is 0x11 then 0x22, and `gpr[7]` ends at 0x22.
- Stream:
  - 100 back-to-back pushes to random registers with `wb_stall`=0 → `in_ready` stays 1 throughout.
  - `retire_cnt`=100 two cycles after the last push.
  - Final `gpr` contents match a reference model.
- Full boundary:
  - Count=2, stalled, `in_valid`=1 → no push occurs.
  - Deassert the stall: one pop, and `in_ready` rises the next cycle.
  - The held bundle is then accepted exactly once.
- Non-writing entries:
  - Push we=0, waddr=9, wdata=0xDEAD → `gpr[9]` unchanged, no bypass on x9, `retire_cnt` increments, `commit_we`=0.
